// File: rtl/bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    localparam int BCD_DIGIT_W = 4;

    // Decimal digits needed for a WIDTH-bit unsigned value: ceil(w * log10(2)).
    // 30103/100000 approximates log10(2) closely enough for any w up to 32.
    function automatic int digits_for_width(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: adds 3 (mod 16) to a BCD digit of 5 or more.
// Purely combinational, zero latency, no flow control.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per cycle.
// Result valid WIDTH cycles after acceptance; holds in DONE until out_ready, accepts only in IDLE.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              bin_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          busy
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_width_chk
            $error("bin_to_bcd_seq: WIDTH %0d outside 4..32", WIDTH);
        end
        if (DIGITS < digits_for_width(WIDTH)) begin : g_digits_chk
            $error("bin_to_bcd_seq: DIGITS %0d too small for WIDTH %0d (need %0d)",
                   DIGITS, WIDTH, digits_for_width(WIDTH));
        end
    endgenerate

    conv_state_t      state;
    conv_state_t      state_next;
    logic [WIDTH-1:0] bin_sr;
    logic [BCD_W-1:0] bcd_sr;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] cnt;
    logic             unused_adj_msb;

    genvar d;
    generate
        for (d = 0; d < DIGITS; d++) begin : g_digit
            bcd_add3_digit u_add3 (
                .digit    (bcd_sr [d*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .adjusted (bcd_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // The digit-count check guarantees this bit is zero whenever it would be shifted out.
    assign unused_adj_msb = bcd_adj[BCD_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Corrected digits and binary word shift as one {bcd, bin} register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr <= bin_in;
                        bcd_sr <= '0;
                        cnt    <= CNT_LAST;
                    end
                end
                SHIFT: begin
                    bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
                    bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd_out = bcd_sr;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly upstream of the display and digit path. It turns an unsigned binary word into a packed multi-digit BCD value.
- Reuses the per-digit "if >4 add 3" correction that the hex-to-BCD digit stage performs combinationally.
- Uses a valid/ready handshake on both sides, one bit per cycle.

Parameters:
- WIDTH, 8: width of the binary input, legal range 4..32.
- DIGITS, 3: number of BCD output digits.
  - Must be at least ceil(WIDTH*log10(2)).
  - An elaboration-time assertion fails if it is smaller.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- bin_in  input  WIDTH  unsigned binary operand.
- out_valid  output  1  bcd_out holds a finished result.
- out_ready  input  1  downstream accepts the result.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 is in bits [3:0] and is the least significant.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and takes priority over every other input.
- Reset values:
  - State = IDLE.
  - in_ready = 1, out_valid = 0, busy = 0.
  - bcd_out = 0, internal shift register = 0, bit counter = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid=1:
    - latch bin_in into the binary shift register;
    - clear the BCD register;
    - load counter = WIDTH-1;
    - move to SHIFT.
- SHIFT, one iteration per cycle:
  1. Every digit whose value is ≥5 gets 3 added, modulo 16 per digit, with no carry between digits.
  2. The whole {bcd, bin} register shifts left 1; the binary MSB enters bcd bit 0.
  - When counter = 0, that shift is the last one: go to DONE. Otherwise decrement the counter.
  - in_valid is ignored in SHIFT.
- DONE:
  - out_valid = 1.
  - bcd_out is stable and is driven straight from a register.
  - On an edge with out_ready=1: go to IDLE; out_valid drops the next cycle.
  - With out_ready low, hold indefinitely with no change to bcd_out.
- Latency:
  - Acceptance edge E0.
  - Shifts occur on edges E1..E_WIDTH.
  - out_valid is high from just after E_WIDTH.
  - Throughput is one conversion per WIDTH+2 cycles at minimum. No acceptance happens in the cycle the output handshake occurs.
- bcd_out between conversions:
  - Holds the last result after leaving DONE.
  - Cleared only by rst or by a new acceptance.
  - It may show intermediate values during SHIFT, so consumers qualify it with out_valid.
- Arithmetic and overflow:
  - All digit results are in 0..9 at DONE by construction.
  - No overflow output: the DIGITS assertion guarantees range.
- Reset mid-operation: rst in SHIFT or DONE aborts the conversion and returns to the reset values on that edge. There is no partial output.
- Simultaneous in_valid and rst: rst wins and nothing is accepted.

Decomposition:
- Package bcd_pkg contains:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  - localparam BCD_DIGIT_W = 4;
  - function digits_for_width(int w), returning the minimum digit count used by the assertion.
- Sub-module bcd_add3_digit:
  - Combinational: 4-bit in, 4-bit out, adds 3 when the input is ≥5.
  - Instantiated DIGITS times in a generate loop.
  - Checked exhaustively on its own over all 16 inputs. For inputs 0..9 the expected outputs are 0,1,2,3,4,8,9,10,11,12.

Test Plan:
- WIDTH=8, bin_in=255, out_ready=1 → out_valid rises 8 cycles after acceptance; bcd_out=12'h255; in_ready returns 1 one cycle after the output handshake.
- WIDTH=8, bin_in=0, then bin_in=99 → bcd_out=12'h000, then 12'h099. This exercises the add-3 path on digit 0 during the shifts.
- Back-pressure: bin_in=128, out_ready held 0 for 5 cycles after out_valid → out_valid stays 1, bcd_out stays 12'h128, in_ready stays 0, and a second in_valid is not accepted. Raising out_ready completes the handshake.
- Reset mid-conversion: assert rst on the 4th SHIFT cycle of bin_in=200 → next cycle state IDLE, out_valid=0, bcd_out=0; then a new bin_in=37 yields 12'h037.
- Back-to-back: in_valid held high with values 10, 250 and out_ready=1 → results 12'h010 then 12'h250, each out_valid pulse lasting exactly 1 cycle, with acceptances spaced WIDTH+2 cycles apart.
- WIDTH=16, DIGITS=5: bin_in=65535 → 20'h65535; bin_in=10000 → 20'h10000. Separately, elaborating WIDTH=16 with DIGITS=4 must fail the assertion.
